// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus sequencer: pattern modes, FSM states
// and the combinational pattern generator used by the datapath.
package stim_pkg;

    localparam logic [1:0] MODE_BIN   = 2'd0;
    localparam logic [1:0] MODE_GRAY  = 2'd1;
    localparam logic [1:0] MODE_WALK1 = 2'd2;
    localparam logic [1:0] MODE_WALK0 = 2'd3;

    // Working width of the pattern function; callers cast down to NO_OUT.
    localparam int PAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Vector k of the selected family, masked to 'width' bits.
    function automatic logic [PAT_W-1:0] pattern_vec(
        input logic [1:0]       mode,
        input logic [PAT_W-1:0] k,
        input int               width
    );
        logic [PAT_W-1:0] v;
        logic [PAT_W-1:0] mask;
        v    = '0;
        mask = (width >= PAT_W) ? '1 : ((PAT_W'(1) << width) - PAT_W'(1));
        case (mode)
            MODE_BIN:   v = k;
            MODE_GRAY:  v = k ^ (k >> 1);
            MODE_WALK1: v = PAT_W'(1) << k;
            MODE_WALK0: v = ~(PAT_W'(1) << k);
            default:    v = k;
        endcase
        return v & mask;
    endfunction

endpackage

// File: rtl/stim_gap_cnt.sv
// Loadable down-counter timing the idle gap between vectors.
// Ports: clk, rst (async, high), load/load_val, dec, zero (count==0).
module stim_gap_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/stim_sequencer.sv
// Start/abort controlled stimulus engine: binary, Gray, walking-one and
// walking-zero vectors over a valid/ready handshake with an optional idle gap.
// Ports: clk, rst (async, high), start, abort, mode[1:0] -> control side;
//        stimul, stim_valid, stim_ready, vec_idx -> DUT side; busy, done.
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int NO_OUT   = 4,
    parameter int HOLD_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    output logic [NO_OUT-1:0] stimul,
    output logic              stim_valid,
    input  logic              stim_ready,
    output logic [NO_OUT:0]   vec_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] GAP_LOAD =
        (HOLD_CYC > 0) ? 8'(HOLD_CYC - 1) : 8'd0;
    localparam logic [NO_OUT:0] LAST_CNT  = {1'b0, {NO_OUT{1'b1}}};
    localparam logic [NO_OUT:0] LAST_WALK = (NO_OUT+1)'(NO_OUT - 1);

    state_t state_q;
    state_t state_d;

    logic [1:0]        mode_reg;
    logic              mode_ld;
    logic              vec_ld;
    logic [NO_OUT-1:0] vec_d;
    logic [NO_OUT:0]   idx_d;
    logic [NO_OUT:0]   idx_inc;
    logic [NO_OUT-1:0] pat_first;
    logic [NO_OUT-1:0] pat_next;
    logic              last;
    logic              gap_ld;
    logic              gap_dec;
    logic              gap_zero;

    assign idx_inc   = vec_idx + (NO_OUT+1)'(1);
    assign pat_first = NO_OUT'(pattern_vec(mode, '0, NO_OUT));
    assign pat_next  = NO_OUT'(pattern_vec(mode_reg, PAT_W'(idx_inc), NO_OUT));

    // Walking modes run NO_OUT vectors, counting modes 2^NO_OUT.
    assign last = mode_reg[1] ? (vec_idx == LAST_WALK)
                              : (vec_idx == LAST_CNT);

    assign gap_dec = (state_q == ST_GAP);

    stim_gap_cnt #(
        .W(8)
    ) u_gap (
        .clk     (clk),
        .rst     (rst),
        .load    (gap_ld),
        .load_val(GAP_LOAD),
        .dec     (gap_dec),
        .zero    (gap_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            stimul   <= '0;
            vec_idx  <= '0;
            mode_reg <= MODE_BIN;
        end else begin
            state_q <= state_d;
            if (vec_ld) begin
                stimul  <= vec_d;
                vec_idx <= idx_d;
            end
            if (mode_ld) begin
                mode_reg <= mode;
            end
        end
    end

    // Abort wins over everything and leaves stimul/vec_idx untouched.
    always_comb begin
        state_d = state_q;
        mode_ld = 1'b0;
        vec_ld  = 1'b0;
        vec_d   = stimul;
        idx_d   = vec_idx;
        gap_ld  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_SEND;
                        mode_ld = 1'b1;
                        vec_ld  = 1'b1;
                        vec_d   = pat_first;
                        idx_d   = '0;
                    end
                end
                ST_SEND: begin
                    if (stim_ready) begin
                        if (last) begin
                            state_d = ST_DONE;
                        end else if (HOLD_CYC == 0) begin
                            vec_ld = 1'b1;
                            vec_d  = pat_next;
                            idx_d  = idx_inc;
                        end else begin
                            state_d = ST_GAP;
                            gap_ld  = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_zero) begin
                        state_d = ST_SEND;
                        vec_ld  = 1'b1;
                        vec_d   = pat_next;
                        idx_d   = idx_inc;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign stim_valid = (state_q == ST_SEND);
    assign busy       = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign done       = (state_q == ST_DONE);

endmodule
